// File: rtl/nap_countdown.sv
// nap_countdown: MM:SS BCD countdown (load/start/pause/stop) with per-second tick, timed alarm and done pulse
module nap_countdown #(
  parameter int TICK_DIV     = 50000000,
  parameter int ALARM_CYCLES = 150000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] set_mt,
  input  logic [3:0] set_mo,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic       running,
  output logic       paused,
  output logic       alarm,
  output logic       done
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int AW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;
  state_t state, state_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [AW-1:0] acnt, acnt_n;
  logic [15:0] dig_n;
  logic tick, last, nz, a_end, dec_en, load_en, bo, bt, bm;
  function automatic logic [3:0] nd(input logic [3:0] d, input logic [3:0] mx);
    return (d == 4'd0) ? mx : d - 4'd1;
  endfunction
  assign tick    = tcnt == TW'(TICK_DIV - 1);
  assign a_end   = acnt == AW'(ALARM_CYCLES - 1);
  assign nz      = |{min_t, min_o, sec_t, sec_o};
  assign last    = {min_t, min_o, sec_t, sec_o} == 16'h0001;
  assign dec_en  = state == RUN && !stop && !pause && tick;
  assign load_en = state == IDLE && !stop && load;
  assign bo      = sec_o == 4'd0;
  assign bt      = bo && sec_t == 4'd0;
  assign bm      = bt && min_o == 4'd0;
  always_ff @(posedge clock)
    state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = stop ? IDLE
      : state == IDLE  ? ((!load && start && nz) ? RUN : IDLE)
      : state == RUN   ? (pause ? PAUSE : (tick && last) ? ALARM : RUN)
      : state == PAUSE ? (start ? RUN : PAUSE)
      : (a_end ? IDLE : ALARM);
  end
  always_comb begin
    running = state == RUN;
    paused  = state == PAUSE;
    alarm   = state == ALARM;
  end
  always_comb begin
    tcnt_n = (stop || state == IDLE) ? '0
      : (state == RUN && !pause) ? (tick ? '0 : tcnt + TW'(1))
      : tcnt;
    acnt_n = (state == ALARM && !a_end) ? acnt + AW'(1) : '0;
    dig_n  = load_en ? {(set_mt > 4'd5) ? 4'd5 : set_mt, (set_mo > 4'd9) ? 4'd9 : set_mo, 8'h00}
      : dec_en ? {bm ? nd(min_t, 4'd5) : min_t, bt ? nd(min_o, 4'd9) : min_o,
                  bo ? nd(sec_t, 4'd5) : sec_t, nd(sec_o, 4'd9)}
      : {min_t, min_o, sec_t, sec_o};
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      tcnt <= '0;
      acnt <= '0;
      {min_t, min_o, sec_t, sec_o} <= '0;
      done <= 1'b0;
    end else begin
      tcnt <= tcnt_n;
      acnt <= acnt_n;
      {min_t, min_o, sec_t, sec_o} <= dig_n;
      done <= state_n == ALARM && state != ALARM;
    end
  end
endmodule

// File: doc/nap_countdown.md
# nap_countdown

Minutes:seconds BCD countdown engine for the nap timer. Holds a user-loaded MM:SS value and decrements it once per second while running. Each digit is decremented with a borrow-out, which is the same per-digit minus-one operation used elsewhere in the timer path. When the count reaches 00:00 it raises a timed alarm. It sits between the button/setting front end (load, start, pause, stop) and the display driver and buzzer.

## Interface
- TICK_DIV, default 50000000: clock cycles per one-second tick; must be ≥2.
- ALARM_CYCLES, default 150000000: cycles the alarm output stays high; must be ≥1.

- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  reset is synchronous and active-high.
- load  in  1  load set_mt/set_mo into the minute digits and clear the seconds; honoured in IDLE only.
- set_mt  in  4  BCD minute tens.
- set_mo  in  4  BCD minute ones.
- start  in  1  start from IDLE or resume from PAUSE.
- pause  in  1  pause from RUN.
- stop  in  1  cancel from any state, returning to IDLE.
- min_t, min_o, sec_t, sec_o  out  4 each  current BCD digits.
- running  out  1  high in RUN.
- paused  out  1  high in PAUSE.
- alarm  out  1  high in ALARM.
- done  out  1  one-cycle pulse on entering ALARM.

## Operation
- States are IDLE, RUN, PAUSE and ALARM. Reset puts the block in IDLE.
- Reset values: all digits 0, running=0, paused=0, alarm=0, done=0, tick counter 0, alarm counter 0.
- Input priority is stop > load > pause > start, one action per cycle.
- stop: from any state, go to IDLE. The tick counter clears, the digits hold, and alarm drops on the next edge.
- load (IDLE only):
  - min_t <= min(set_mt, 5); min_o <= min(set_mo, 9); sec_t <= 0; sec_o <= 0.
  - load is ignored in RUN, PAUSE and ALARM.
- start:
  - From IDLE, go to RUN only if the digits are not 00:00. The tick counter clears to 0.
  - From PAUSE, go to RUN with the tick counter unchanged, so the partial second is kept.
  - In RUN or ALARM, start is ignored.
- pause: RUN goes to PAUSE. The tick counter and digits freeze.
- Tick counter (RUN only):
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - A tick occurs on the edge where the counter equals TICK_DIV-1.
- Decrement on a tick, using the per-digit rule "if digit==0: borrow=1, digit<=max; else: digit<=digit-1, borrow=0":
  - sec_o always decrements (max 9).
  - sec_t decrements only on sec_o borrow (max 5).
  - min_o decrements only on sec_t borrow (max 9).
  - min_t decrements only on min_o borrow (max 5).
- Terminal count: a tick taken when the digits read 00:01 produces 00:00. On that same edge the state goes to ALARM and the alarm counter clears. A borrow out of min_t cannot occur.
- ALARM:
  - alarm=1; the alarm counter counts 0..ALARM_CYCLES-1.
  - At ALARM_CYCLES-1 the state goes to IDLE. Digits stay at 00:00.
- done is high for exactly the first cycle in which the state is ALARM.

## Timing
- All outputs are registered. Digits update on the tick edge and are visible the following cycle.
- The first tick after start from IDLE comes TICK_DIV cycles after the edge that entered RUN.
- start to alarm: the loaded seconds × TICK_DIV cycles. alarm is visible the cycle after the final tick edge.
- alarm stays high for exactly ALARM_CYCLES cycles unless stop arrives earlier.
- Pause/resume keeps the counter phase: the time from start to alarm grows by exactly the number of cycles spent in PAUSE.
- pause and tick on the same edge: pause wins. No decrement happens and the counter holds at TICK_DIV-1, so the tick fires on the first RUN edge after resume.
- stop and tick on the same edge: stop wins and the digits do not decrement.
- reset mid-RUN or mid-ALARM: all reset values apply on the next edge.

## Test plan
1. TICK_DIV=4, ALARM_CYCLES=8. load with 0,1 → 01:00. start → after 4 cycles reads 00:59, after 8 cycles 00:58. After 240 cycles from start: 00:00, alarm=1, done pulses once. alarm is high for 8 cycles, then IDLE.
2. Borrow chain: load 1,0 → 10:00. One tick → 09:59 (min_t 1→0, min_o 0→9, sec_t 0→5, sec_o 0→9).
3. Clamping: load set_mt=9, set_mo=12 → 59:00. Load 0,0 then start → stays IDLE, running=0.
4. Pause/resume: start from 01:00, pause at cycle 2 of the tick count, wait 20 cycles, resume → next decrement (00:59) exactly 2 cycles after resume. Pause asserted on a tick edge → no decrement.
5. stop during RUN at 00:42 → IDLE, digits hold 00:42. stop during ALARM → alarm drops the next cycle. load during RUN → ignored.
6. reset asserted mid-RUN → next cycle all digits 0, running=0. load and start then behave as from power-up.
